// File: rtl/axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// axis_frame_arbiter
//   Frame-aware round-robin arbiter sharing one AXI-stream sink between S_COUNT
//   sources. A granted source keeps the grant until its tlast beat transfers.
//   The output stage is a single register slice tagged with the source index.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   s_axis_*            S_COUNT concatenated source ports; port i uses slice i
//   s_axis_tready       per-port ready, at most one bit high
//   m_axis_*            registered copy of the granted beat
//   m_axis_tid          index of the source of the current output beat
//   status_busy         high while a frame is being forwarded
//   status_grant        current or most recent grant index
// -----------------------------------------------------------------------------
module axis_frame_arbiter #(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 1,
    parameter int ID_WIDTH    = $clog2(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic                          status_busy,
    output logic [ID_WIDTH-1:0]           status_grant
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                               state;
    logic [ID_WIDTH-1:0]                  grant;
    logic [ID_WIDTH-1:0]                  last_grant;
    logic [ID_WIDTH-1:0]                  arb_idx;
    logic                                 arb_found;
    logic [ID_WIDTH:0]                    arb_sum;
    logic                                 out_ready;
    logic                                 accept;

    logic [S_COUNT-1:0][DATA_WIDTH-1:0]   port_data;
    logic [S_COUNT-1:0][KEEP_WIDTH-1:0]   port_keep;
    logic [S_COUNT-1:0][USER_WIDTH-1:0]   port_user;
    logic [KEEP_WIDTH-1:0]                sel_keep;

    // The output slice can take a beat when it is empty or draining this cycle.
    assign out_ready = !m_axis_tvalid || m_axis_tready;
    assign accept    = (state == ACTIVE) && s_axis_tvalid[grant] && out_ready;
    assign sel_keep  = (KEEP_ENABLE != 0) ? port_keep[grant] : {KEEP_WIDTH{1'b1}};

    for (genvar i = 0; i < S_COUNT; i++) begin : g_port
        assign port_data[i]     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign port_keep[i]     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        assign port_user[i]     = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        assign s_axis_tready[i] = (state == ACTIVE) && (grant == ID_WIDTH'(i)) && out_ready;
    end

    // Round-robin scan starting just after the previous winner. The sum is one
    // bit wider than an index so the modulo wrap works for any S_COUNT.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        for (int k = 1; k <= S_COUNT; k++) begin
            arb_sum = {1'b0, last_grant} + (ID_WIDTH+1)'(k);
            if (arb_sum >= (ID_WIDTH+1)'(S_COUNT))
                arb_sum = arb_sum - (ID_WIDTH+1)'(S_COUNT);
            if (!arb_found && s_axis_tvalid[arb_sum[ID_WIDTH-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_sum[ID_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= ID_WIDTH'(S_COUNT - 1);
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            m_axis_tid    <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant <= arb_idx;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Release only on the tlast beat; a stalled source keeps the grant.
                    if (accept && s_axis_tlast[grant]) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                m_axis_tdata  <= port_data[grant];
                m_axis_tkeep  <= sel_keep;
                m_axis_tlast  <= s_axis_tlast[grant];
                m_axis_tuser  <= port_user[grant];
                m_axis_tid    <= grant;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    assign status_busy  = (state == ACTIVE);
    assign status_grant = grant;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_arbiter
//   Self-checking bench for axis_frame_arbiter. Per-port source queues feed the
//   DUT; every queued beat is also pushed to a per-source expected queue that
//   is popped when the beat leaves m_axis. Scenario tasks run in sequence.
// -----------------------------------------------------------------------------
module tb_axis_frame_arbiter;
    localparam int S  = 4;
    localparam int DW = 8;
    localparam int KW = 1;
    localparam int UW = 1;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [S*DW-1:0] s_tdata;
    logic [S*KW-1:0] s_tkeep;
    logic [S-1:0]    s_tvalid, s_tready, s_tlast;
    logic [S*UW-1:0] s_tuser;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid, m_tready, m_tlast;
    logic [UW-1:0]   m_tuser;
    logic [IW-1:0]   m_tid;
    logic            status_busy;
    logic [IW-1:0]   status_grant;

    axis_frame_arbiter #(
        .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_ENABLE(0), .KEEP_WIDTH(KW), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .m_axis_tid(m_tid), .status_busy(status_busy), .status_grant(status_grant)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // beat encoding {tuser, tlast, tdata}
    logic [9:0] src_q [S][$];
    logic [9:0] exp_q [S][$];
    int         grant_log [$];
    int         gap_log [$];
    logic [S-1:0] src_en;
    bit         rand_src, rand_rdy;
    logic       rdy_val;
    int         cyc, last_end_cyc, cur_tid;
    bit         frame_open;
    int         wait_cnt [S];

    task automatic push_frame(input int p, input int n, input logic [7:0] base);
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            d = base + 8'(k);
            src_q[p].push_back({^d, (k == n - 1), d});
            exp_q[p].push_back({^d, (k == n - 1), d});
        end
    endtask

    task automatic clear_tb();
        for (int i = 0; i < S; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            wait_cnt[i] = 0;
        end
        frame_open = 1'b0;
        grant_log.delete();
        gap_log.delete();
    endtask

    function automatic bit pending();
        bit b = m_tvalid || status_busy;
        for (int i = 0; i < S; i++)
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    // Source drivers plus output monitor. Observes at negedge, drives at posedge+1.
    task automatic driver();
        logic [S-1:0] xfer;
        logic [9:0]   e;
        logic         v;
        int           t;
        forever begin
            @(negedge clk);
            cyc++;
            xfer = s_tvalid & s_tready;
            checks++;
            if ($countones(s_tready) > 1) begin
                errors++;
                $display("FAIL ready_onehot: s_axis_tready=%b, required at most one bit", s_tready);
            end
            if (m_tvalid && m_tready) begin
                t = int'(m_tid);
                if (!frame_open) begin
                    grant_log.push_back(t);
                    gap_log.push_back(cyc - last_end_cyc);
                    frame_open = 1'b1;
                    cur_tid = t;
                    wait_cnt[t] = 0;
                    for (int j = 0; j < S; j++) begin
                        if (j != t && s_tvalid[j]) begin
                            wait_cnt[j]++;
                            checks++;
                            if (wait_cnt[j] > S) begin
                                errors++;
                                $display("FAIL starvation: port %0d waited %0d frames, required <= %0d", j, wait_cnt[j], S);
                            end
                        end
                    end
                end else begin
                    checks++;
                    if (t != cur_tid) begin
                        errors++;
                        $display("FAIL interleave: tid %0d inside frame of tid %0d", t, cur_tid);
                    end
                end
                checks++;
                if (exp_q[t].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: tid %0d data %h, required no beat", t, m_tdata);
                end else begin
                    e = exp_q[t].pop_front();
                    if ({m_tuser, m_tlast, m_tdata} !== e || m_tkeep !== 1'b1) begin
                        errors++;
                        $display("FAIL beat_tid%0d: got u/l/d=%b/%b/%h keep=%b, required %b/%b/%h keep=1",
                                 t, m_tuser, m_tlast, m_tdata, m_tkeep, e[9], e[8], e[7:0]);
                    end
                end
                if (m_tlast) begin
                    frame_open = 1'b0;
                    last_end_cyc = cyc;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < S; i++) begin
                if (xfer[i] && src_q[i].size() > 0) src_q[i].delete(0);
                if (!src_en[i] || src_q[i].size() == 0) v = 1'b0;
                else if (s_tvalid[i] && !xfer[i])      v = 1'b1;
                else                                   v = rand_src ? ($urandom_range(0, 1) == 1) : 1'b1;
                s_tvalid[i] = v;
                if (v) {s_tuser[i], s_tlast[i], s_tdata[i*DW +: DW]} = src_q[i][0];
                else   {s_tuser[i], s_tlast[i], s_tdata[i*DW +: DW]} = 10'($urandom);
            end
            m_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (pending() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL %s_drain: traffic pending after %0d cycles, required all delivered", name, n);
        end
    endtask

    task automatic wait_out(input int tid, input string name);
        int n = 0;
        @(negedge clk);
        while (!(m_tvalid && int'(m_tid) == tid) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(m_tvalid && int'(m_tid) == tid)) begin
            errors++;
            $display("FAIL %s_start: no output beat from tid %0d, required one within 30 cycles", name, tid);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_tb();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== '0 || status_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: mvalid=%b sready=%b busy=%b, required 0/0000/0", m_tvalid, s_tready, status_busy);
        end
        checks++;
        if (m_tdata !== '0 || m_tlast !== 1'b0 || m_tuser !== '0 || m_tid !== '0 || status_grant !== '0) begin
            errors++;
            $display("FAIL reset_data: data=%h last=%b user=%b tid=%0d grant=%0d, required all 0",
                     m_tdata, m_tlast, m_tuser, m_tid, status_grant);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== '0 || status_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: mvalid=%b sready=%b busy=%b, required 0/0000/0", m_tvalid, s_tready, status_busy);
        end
    endtask

    task automatic test_single_frame();
        int n = 0;
        clear_tb();
        push_frame(2, 3, 8'hA1);
        @(negedge clk);
        while (!s_tvalid[2] && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_tready[2] !== 1'b0) begin
            errors++;
            $display("FAIL arb_latency0: tready[2]=%b with first tvalid, required 0", s_tready[2]);
        end
        @(negedge clk);
        checks++;
        if (s_tready[2] !== 1'b1) begin
            errors++;
            $display("FAIL arb_latency1: tready[2]=%b one cycle after tvalid, required 1", s_tready[2]);
        end
        wait_drain("single");
        checks++;
        if (grant_log.size() != 1 || grant_log[0] != 2) begin
            errors++;
            $display("FAIL single_grant: %0d frames first tid %0d, required 1 frame tid 2",
                     grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
        end
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int p = 0; p < S; p++) push_frame(p, 2, 8'(16 * (p + 1)));
        push_frame(0, 2, 8'h50);
        wait_drain("rr");
        checks++;
        if (grant_log.size() != 5) begin
            errors++;
            $display("FAIL rr_count: %0d frames, required 5", grant_log.size());
        end
        for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
            checks++;
            if (grant_log[k] != exp_order[k]) begin
                errors++;
                $display("FAIL rr_order[%0d]: tid %0d, required %0d", k, grant_log[k], exp_order[k]);
            end
            if (k > 0) begin
                checks++;
                if (gap_log[k] != 2) begin
                    errors++;
                    $display("FAIL rr_bubble[%0d]: frame gap %0d cycles, required 2", k, gap_log[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_tb();
        push_frame(2, 1, 8'hC0);
        push_frame(2, 1, 8'hC1);
        push_frame(2, 1, 8'hC2);
        wait_drain("b2b");
        checks++;
        if (grant_log.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: %0d frames, required 3", grant_log.size());
        end
        for (int k = 0; k < 3 && k < grant_log.size(); k++) begin
            checks++;
            if (grant_log[k] != 2 || (k > 0 && gap_log[k] != 2)) begin
                errors++;
                $display("FAIL b2b[%0d]: tid %0d gap %0d, required tid 2 gap 2", k, grant_log[k], gap_log[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] hold_d;
        clear_tb();
        push_frame(1, 6, 8'h60);
        wait_out(1, "stall");
        rdy_val = 1'b0;
        @(negedge clk);
        hold_d = m_tdata;
        checks++;
        if (hold_d !== 8'h61) begin
            errors++;
            $display("FAIL stall_beat: held data %h, required 61", hold_d);
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== hold_d || s_tready[1] !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: mvalid=%b data=%h tready1=%b, required 1/%h/0",
                         c, m_tvalid, m_tdata, s_tready[1], hold_d);
            end
        end
        rdy_val = 1'b1;
        wait_drain("stall");
    endtask

    task automatic test_hold_grant();
        clear_tb();
        push_frame(3, 6, 8'h30);
        wait_out(3, "gap");
        src_en[3] = 1'b0;
        push_frame(0, 2, 8'h40);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (status_grant !== 2'd3 || status_busy !== 1'b1 || s_tready[0] !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold[%0d]: grant=%0d busy=%b tready0=%b, required 3/1/0",
                         c, status_grant, status_busy, s_tready[0]);
            end
        end
        src_en[3] = 1'b1;
        wait_drain("gap");
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 3 || grant_log[1] != 0) begin
            errors++;
            $display("FAIL gap_order: %0d frames, required order 3 then 0", grant_log.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        clear_tb();
        push_frame(1, 4, 8'hB0);
        @(negedge clk);
        while (!(m_tvalid && m_tdata == 8'hB0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== '0 || status_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: mvalid=%b sready=%b busy=%b, required 0/0000/0", m_tvalid, s_tready, status_busy);
        end
        clear_tb();
        @(posedge clk);
        #3;
        rst = 1'b0;
        push_frame(2, 2, 8'hD0);
        push_frame(0, 2, 8'hE0);
        wait_drain("rst_mid");
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
            errors++;
            $display("FAIL rst_priority: first tid %0d of %0d frames, required 0 then 2",
                     (grant_log.size() > 0) ? grant_log[0] : -1, grant_log.size());
        end
    endtask

    task automatic test_random();
        clear_tb();
        rand_src = 1'b1;
        rand_rdy = 1'b1;
        repeat (10000) begin
            @(negedge clk);
            for (int p = 0; p < S; p++)
                if (src_q[p].size() < 6 && $urandom_range(0, 7) == 0)
                    push_frame(p, $urandom_range(1, 4), 8'($urandom));
        end
        rand_src = 1'b0;
        rand_rdy = 1'b0;
        rdy_val  = 1'b1;
        wait_drain("random");
        checks++;
        if (grant_log.size() < 100) begin
            errors++;
            $display("FAIL random_volume: %0d frames, required >= 100", grant_log.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '1; s_tlast = '0; s_tuser = '0;
        m_tready = 1'b1; rdy_val = 1'b1; src_en = '1;
        rand_src = 1'b0; rand_rdy = 1'b0;
        cyc = 0; last_end_cyc = 0; cur_tid = 0; frame_open = 1'b0;
        for (int i = 0; i < S; i++) wait_cnt[i] = 0;
        fork
            driver();
        join_none
        test_reset();
        test_single_frame();
        test_round_robin();
        test_back_to_back();
        test_backpressure();
        test_hold_grant();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
